// File: rtl/count_game_pkg.sv
// Shared types and default timing for the count game control stage.
package count_game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NUM_W            = 3;
    localparam int DEF_MAX_NUM      = 7;
    localparam int DEF_DEB_CYCLES   = 20;
    localparam int DEF_BUZZ_CYCLES  = 500;
    localparam int DEF_GUARD_CYCLES = 2;

endpackage

// File: rtl/key_debounce.sv
// Raw key conditioning: 2-flop synchroniser, saturating debounce counter and
// press detector producing a single-cycle pulse on the debounced rising edge.
module key_debounce
    import count_game_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_lvl,
    output logic key_rise
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [1:0]       sync;
    logic [1:0]       vld_pipe;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // A key held through reset must not count as a press: the pulse is only
    // armed once a genuine (post-reset) released sample has been seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync     <= '0;
            vld_pipe <= '0;
            armed    <= 1'b0;
            cnt      <= '0;
            key_lvl  <= 1'b0;
            key_rise <= 1'b0;
        end else begin
            sync     <= {sync[0], key_raw};
            vld_pipe <= {vld_pipe[0], 1'b1};
            armed    <= armed | (vld_pipe[1] & ~sync[1]);
            key_rise <= 1'b0;
            if (sync[1] == key_lvl) begin
                cnt <= '0;
            end else if (cnt >= CNT_W'(DEB_CYCLES - 1)) begin
                cnt      <= '0;
                key_lvl  <= sync[1];
                key_rise <= sync[1] & armed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_game_ctrl.sv
// Count game control: key conditioning, start-value latch and IDLE/LOAD/RUN/DONE
// sequencing of the countdown counter. COUNT_GAME_AUTO_RESTART_EN enables auto-restart.
module count_game_ctrl
    import count_game_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int MAX_NUM      = DEF_MAX_NUM,
    parameter int BUZZ_CYCLES  = DEF_BUZZ_CYCLES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_stop,
    input  logic [NUM_W-1:0] sw_num,
    input  logic             cnt_zero,
    output logic             st,
    output logic [NUM_W-1:0] num,
    output logic             busy,
    output logic             done,
    output logic             buzz
);

    localparam int G_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam int B_W = (BUZZ_CYCLES > 0) ? $clog2(BUZZ_CYCLES + 1) : 1;

    state_t                state_q, state_d;
    logic                  start_p, stop_p, start_lvl, stop_lvl, unused_lvl;
    logic [1:0][NUM_W-1:0] sw_pipe;
    logic [NUM_W-1:0]      sw_sync, num_clamp, num_d;
    logic                  sw_nz, guard_done, buzz_expired, entering_done;
    logic [G_W-1:0]        guard_q, guard_d;
    logic [B_W-1:0]        bcnt_q, bcnt_d;
    logic                  st_d, busy_d, done_d, buzz_d;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_start),
        .key_lvl  (start_lvl),
        .key_rise (start_p)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
        .clk      (clk),
        .rst      (rst),
        .key_raw  (key_stop),
        .key_lvl  (stop_lvl),
        .key_rise (stop_p)
    );

    assign unused_lvl = start_lvl ^ stop_lvl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sw_pipe <= '0;
        else      sw_pipe <= {sw_pipe[0], sw_num};
    end

    assign sw_sync      = sw_pipe[1];
    assign sw_nz        = |sw_sync;
    assign num_clamp    = (int'(sw_sync) > MAX_NUM) ? NUM_W'(MAX_NUM) : sw_sync;
    assign guard_done   = (guard_q >= G_W'(GUARD_CYCLES));
    assign buzz_expired = (bcnt_q == B_W'(BUZZ_CYCLES));

    // Stop outranks every other event in RUN and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_p && !stop_p && sw_nz) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN: begin
                if (stop_p)                      state_d = IDLE;
                else if (cnt_zero && guard_done) state_d = DONE;
            end
            DONE: begin
                if (stop_p)                 state_d = IDLE;
                else if (start_p && sw_nz)  state_d = LOAD;
`ifdef COUNT_GAME_AUTO_RESTART_EN
                else if (buzz_expired)      state_d = sw_nz ? LOAD : IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they change on the entry edge.
    always_comb begin
        entering_done = (state_d == DONE) && (state_q != DONE);
        st_d          = (state_d == RUN) || (state_d == DONE);
        busy_d        = (state_d == LOAD) || (state_d == RUN);
        done_d        = (state_d == DONE);
        buzz_d        = done_d && (entering_done || !buzz_expired);
        num_d         = (state_d == LOAD) ? num_clamp : num;

        guard_d = guard_q;
        if (state_q != RUN)  guard_d = '0;
        else if (!guard_done) guard_d = guard_q + 1'b1;

        bcnt_d = bcnt_q;
        if (entering_done)                         bcnt_d = B_W'(1);
        else if (state_q == DONE && !buzz_expired) bcnt_d = bcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            st      <= 1'b0;
            num     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            buzz    <= 1'b0;
            guard_q <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            st      <= st_d;
            num     <= num_d;
            busy    <= busy_d;
            done    <= done_d;
            buzz    <= buzz_d;
            guard_q <= guard_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_count_game_ctrl.sv
// Bench for count_game_ctrl: directed scenarios plus random key/switch traffic,
// all checked cycle by cycle against a behavioural model of the game rules.
module tb_count_game_ctrl;

    localparam int DEB = 4, BUZZ = 10, GUARD = 2, MAXN = 7;
    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_DONE = 3;

    logic       clk = 1'b0, rst = 1'b0;
    logic       key_start = 1'b0, key_stop = 1'b0, cnt_zero = 1'b0;
    logic [2:0] sw_num = 3'd0;
    logic       st, busy, done, buzz;
    logic [2:0] num;
    logic [6:0] d_out;

    count_game_ctrl #(.DEB_CYCLES(DEB), .MAX_NUM(MAXN), .BUZZ_CYCLES(BUZZ), .GUARD_CYCLES(GUARD)) dut (
        .clk(clk), .rst(rst), .key_start(key_start), .key_stop(key_stop), .sw_num(sw_num),
        .cnt_zero(cnt_zero), .st(st), .num(num), .busy(busy), .done(done), .buzz(buzz)
    );

    always #5 clk = ~clk;
    assign d_out = {st, num, busy, done, buzz};

    int checks = 0, errors = 0;

    // Behavioural model: game state, age in the current state, and key history.
    int  m_state, m_num, m_age, m_edges;
    bit  m_start_p, m_stop_p;
    bit  ks_h[2], kp_h[2];
    int  sw_h[2];
    bit  lvl_s, lvl_p, arm_s, arm_p;
    bit  win_s[$], win_p[$];

    function automatic bit all_differ(input bit q[$], input bit l);
        if (q.size() < DEB) return 1'b0;
        foreach (q[i]) if (q[i] == l) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int clamp(input int v);
        return (v > MAXN) ? MAXN : v;
    endfunction

    function automatic logic [6:0] m_out();
        return {(m_state == S_RUN || m_state == S_DONE), 3'(m_num),
                (m_state == S_LOAD || m_state == S_RUN), (m_state == S_DONE),
                (m_state == S_DONE && m_age < BUZZ)};
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_num = 0; m_age = 0; m_edges = 0;
        m_start_p = 1'b0; m_stop_p = 1'b0;
        ks_h = '{1'b0, 1'b0}; kp_h = '{1'b0, 1'b0}; sw_h = '{0, 0};
        lvl_s = 1'b0; lvl_p = 1'b0; arm_s = 1'b0; arm_p = 1'b0;
        win_s.delete(); win_p.delete();
    endtask

    task automatic model_edge();
        int sw;
        bit sp, tp, ns, np, genuine;
        sw = sw_h[1]; sp = m_start_p; tp = m_stop_p;
        m_edges++;
        case (m_state)
            S_IDLE: if (sp && !tp && sw != 0) begin m_state = S_LOAD; m_num = clamp(sw); end
            S_LOAD: begin m_state = S_RUN; m_age = 0; end
            S_RUN: begin
                if (tp) m_state = S_IDLE;
                else if (cnt_zero && m_age >= GUARD) begin m_state = S_DONE; m_age = 0; end
                else m_age++;
            end
            default: begin
                if (tp) m_state = S_IDLE;
                else if (sp && sw != 0) begin m_state = S_LOAD; m_num = clamp(sw); end
`ifdef COUNT_GAME_AUTO_RESTART_EN
                else if (m_age >= BUZZ - 1) begin
                    if (sw != 0) begin m_state = S_LOAD; m_num = clamp(sw); end
                    else m_state = S_IDLE;
                end
`endif
                else m_age++;
            end
        endcase
        // Synchronised samples are genuine from the third edge after reset.
        genuine = (m_edges >= 3);
        win_s.push_back(ks_h[1]); if (win_s.size() > DEB) void'(win_s.pop_front());
        win_p.push_back(kp_h[1]); if (win_p.size() > DEB) void'(win_p.pop_front());
        if (genuine && !ks_h[1]) arm_s = 1'b1;
        if (genuine && !kp_h[1]) arm_p = 1'b1;
        ns = all_differ(win_s, lvl_s) ? !lvl_s : lvl_s;
        np = all_differ(win_p, lvl_p) ? !lvl_p : lvl_p;
        m_start_p = ns && !lvl_s && arm_s;
        m_stop_p  = np && !lvl_p && arm_p;
        lvl_s = ns; lvl_p = np;
        ks_h[1] = ks_h[0]; ks_h[0] = key_start;
        kp_h[1] = kp_h[0]; kp_h[0] = key_stop;
        sw_h[1] = sw_h[0]; sw_h[0] = int'(sw_num);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int loads = 0;
        rst = 1'b0; key_start = 1'b1; sw_num = 3'd5; model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (d_out !== 7'd0) begin errors++; $display("FAIL reset_state got %b exp %b", d_out, 7'd0); end
        rst = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 15) key_start = 1'b0;
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL reset_hold cyc %0d got %b exp %b", i, d_out, m_out()); end
            if (busy) loads++;
        end
        checks++;
        if (loads != 0) begin errors++; $display("FAIL held_key_load got %0d busy cycles exp 0", loads); end
    endtask

    task automatic test_zero_sw();
        sw_num = 3'd0;
        for (int i = 0; i < 20; i++) begin
            key_start = (i < 8);
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL zero_sw cyc %0d got %b exp %b", i, d_out, m_out()); end
        end
        checks++;
        if ({st, num, busy} !== 5'd0) begin errors++; $display("FAIL zero_sw_idle got %b exp %b", {st, num, busy}, 5'd0); end
    endtask

    task automatic test_bounce();
        int loads = 0;
        sw_num = 3'd5;
        for (int i = 0; i < 34; i++) begin
            key_start = (i < 8) ? ((i / 2) % 2 == 0) : (i < 23);
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL bounce cyc %0d got %b exp %b", i, d_out, m_out()); end
            if (busy && !st) loads++;
        end
        checks++;
        if (loads != 1) begin errors++; $display("FAIL bounce_loads got %0d exp 1", loads); end
        checks++;
        if ({num, st, busy} !== {3'd5, 2'b11}) begin errors++; $display("FAIL bounce_run got %b exp %b", {num, st, busy}, {3'd5, 2'b11}); end
    endtask

    task automatic test_guard_done();
        int early = 0, buzz_n = 0;
        bit found = 1'b0;
        cnt_zero = 1'b0;
        for (int i = 0; i < 16; i++) begin
            key_stop = (i < 7);
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL stop_to_idle cyc %0d got %b exp %b", i, d_out, m_out()); end
        end
        checks++;
        if ({st, busy, done} !== 3'b000) begin errors++; $display("FAIL stop_idle_state got %b exp 000", {st, busy, done}); end
        sw_num = 3'd3; key_start = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL guard_entry cyc %0d got %b exp %b", i, d_out, m_out()); end
            if (st === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL guard_entry_timeout got st=%b exp 1", st); end
        key_start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cnt_zero = (k < 2 || k == 3);
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL guard_run cyc %0d got %b exp %b", k, d_out, m_out()); end
            if (k < 3 && done) early++;
            if (k == 3) begin
                checks++;
                if ({done, buzz} !== 2'b11) begin errors++; $display("FAIL done_entry got %b exp 11", {done, buzz}); end
            end
            if (buzz) buzz_n++;
        end
        cnt_zero = 1'b0;
        checks++;
        if (early != 0) begin errors++; $display("FAIL guard_ignore got %0d early done cycles exp 0", early); end
        checks++;
        if (buzz_n != BUZZ) begin errors++; $display("FAIL buzz_len got %0d exp %0d", buzz_n, BUZZ); end
`ifdef COUNT_GAME_AUTO_RESTART_EN
        checks++;
        if ({num, busy, done} !== {3'd3, 2'b10}) begin errors++; $display("FAIL auto_restart got %b exp %b", {num, busy, done}, {3'd3, 2'b10}); end
`else
        checks++;
        if ({done, buzz, st} !== 3'b101) begin errors++; $display("FAIL done_hold got %b exp 101", {done, buzz, st}); end
`endif
    endtask

    task automatic test_stop_priority();
        int hits = 0;
        sw_num = 3'd5; cnt_zero = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key_start = (i < 7);
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL prio_setup cyc %0d got %b exp %b", i, d_out, m_out()); end
        end
        checks++;
        if ({st, busy} !== 2'b11) begin errors++; $display("FAIL prio_run got %b exp 11", {st, busy}); end
        for (int i = 0; i < 20; i++) begin
            key_stop = (i < 7);
            cnt_zero = m_stop_p;
            if (m_stop_p && m_state == S_RUN) hits++;
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL prio cyc %0d got %b exp %b", i, d_out, m_out()); end
        end
        cnt_zero = 1'b0;
        checks++;
        if (hits != 1) begin errors++; $display("FAIL prio_collision got %0d exp 1", hits); end
        checks++;
        if ({st, busy, done, buzz} !== 4'b0000) begin errors++; $display("FAIL prio_idle got %b exp 0000", {st, busy, done, buzz}); end
    endtask

    task automatic test_reset_mid_run();
        sw_num = 3'd6;
        for (int i = 0; i < 20; i++) begin
            key_start = (i < 7);
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL midrst_setup cyc %0d got %b exp %b", i, d_out, m_out()); end
        end
        checks++;
        if ({num, st} !== {3'd6, 1'b1}) begin errors++; $display("FAIL midrst_run got %b exp %b", {num, st}, {3'd6, 1'b1}); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (d_out !== 7'd0) begin errors++; $display("FAIL midrst_async got %b exp %b", d_out, 7'd0); end
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL midrst_after cyc %0d got %b exp %b", i, d_out, m_out()); end
        end
    endtask

    task automatic test_random();
        int hold_s = 0, hold_p = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold_s == 0) begin key_start = $urandom_range(0, 1); hold_s = $urandom_range(1, 14); end
            if (hold_p == 0) begin key_stop = ($urandom_range(0, 3) == 0); hold_p = $urandom_range(1, 14); end
            hold_s--; hold_p--;
            if ($urandom_range(0, 9) == 0) sw_num = 3'($urandom_range(0, 7));
            cnt_zero = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if (d_out !== m_out()) begin errors++; $display("FAIL random cyc %0d got %b exp %b", i, d_out, m_out()); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_sw();
        test_bounce();
        test_guard_done();
        test_stop_priority();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
